mem_pattern_initiator: RTL and testbench
========================================

Name: mem_pattern_initiator

Overview:
- Self-checking bus initiator that drives the single-cycle data-memory interface: Address, MemWrite, Write_data, Write_strb, MemRead, Read_data.
- It occupies the CPU's side of that interface. It writes an LFSR pattern over a word range, reads the range back, and compares each word.
- It validates memory models and emulator memory mapping independently of the CPU. Results are exposed for host readback or trigger logic.

Parameters:
- ADDR_BASE, 32'h0, byte address of the first word; bits [1:0] must be 0.
- NWORDS, 256, number of words tested; legal range 1..65535.
- SEED, 32'h1, LFSR initial value; 0 is replaced by 32'h1.
- POLY, 32'h80200003, Galois LFSR feedback polynomial.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin test; sampled only in IDLE.
- busy  out  1  high in WRITE and READ states.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  result of the last completed test; held until the next start.
- err_count  out  16  mismatch count, saturating at 16'hFFFF.
- fail_addr  out  32  address of the first mismatch.
- fail_exp  out  32  expected data at the first mismatch.
- fail_got  out  32  read data at the first mismatch.
- Address  out  32  memory byte address.
- MemWrite  out  1  write enable.
- Write_data  out  32  write data.
- Write_strb  out  4  byte strobes; always 4'hF when MemWrite is high, otherwise 4'h0.
- MemRead  out  1  read enable.
- Read_data  in  32  combinational read data for the current Address, valid in the same cycle.

Behaviour:
- One clock domain (clk); rst is synchronous and active-high.
- Reset:
  - State is IDLE.
  - busy, done, pass, err_count, fail_* are all 0.
  - Address, Write_data, Write_strb are 0.
  - MemWrite and MemRead are gated combinationally by !rst, so no access occurs in any cycle where rst is high, including mid-test.
  - Reset mid-test aborts the test with no done pulse.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - All memory strobes are 0.
  - start=1 → WRITE. Set idx=0, lfsr=SEED, err_count=0, pass=0, fail_*=0.
- WRITE:
  - MemWrite=1; Address=ADDR_BASE+4*idx, wrapping mod 2^32; Write_data=lfsr.
  - Each cycle: idx++ and lfsr=next(lfsr).
  - idx==NWORDS-1 → READ, with idx=0 and lfsr=SEED.
- READ:
  - MemRead=1; Address=ADDR_BASE+4*idx.
  - Each cycle, compare Read_data against lfsr.
  - On mismatch, increment err_count (saturating). On the first mismatch (err_count==0), capture fail_addr, fail_exp=lfsr, fail_got=Read_data.
  - idx==NWORDS-1 → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - pass=1 iff total mismatches == 0, including the comparison from the final READ cycle.
  - Next state is IDLE.
- LFSR step: next(l) = (l>>1) ^ (l[0] ? POLY : 0).
- Latency: start sampled at edge 0 gives WRITE in cycles 1..N, READ in cycles N+1..2N, and done in cycle 2N+1, where N=NWORDS.
- start while busy or in DONE is ignored.
- A start in the cycle immediately after DONE begins a new test.
- NWORDS=1: one WRITE cycle, one READ cycle, then DONE.
- Each write lands at the posedge that ends its WRITE cycle. Every read therefore follows its write by at least one edge.

Decomposition:
- Package mem_pattern_pkg holds:
  - state enum {IDLE, WRITE, READ, DONE};
  - DEFAULT_POLY constant;
  - function lfsr_next(l, poly).
- One sub-module, mem_pattern_lfsr, with ports clk, load, step, seed, and value. It handles the SEED==0 substitution.
- Address generation, comparison, and the FSM live in the top.

Test Plan (memory: ideal 1024-word RAM; NWORDS=4, SEED=1, ADDR_BASE=0 unless noted):
- Fault-free: pulse start → writes to 0x0,0x4,0x8,0xC of 0x00000001, 0x80200003, 0xC0300002, 0x60180001 with Write_strb=F. Reads return the same; done in cycle 9; pass=1, err_count=0.
- Stuck bit: force Read_data[3]=1 for address 0x4 → pass=0, err_count=1, fail_addr=0x4, fail_exp=0x80200003, fail_got=0x8020000B.
- Multiple faults: corrupt reads at 0x8 and 0xC → err_count=2; fail_addr=0x8 (first mismatch only).
- Reset mid-test: assert rst in cycle 2 of WRITE → MemWrite=0 in that cycle, state IDLE, no done pulse. Subsequent start completes with pass=1.
- start while busy: pulse start in cycle 3 → ignored, done still occurs only in cycle 9. Back-to-back start right after DONE → second test with done in cycle 9 relative to that start.
- Edge params: ADDR_BASE=32'hFFFFFFFC, NWORDS=2 → addresses 0xFFFFFFFC, then 0x00000000 (wrap). SEED=0 → first write data 0x00000001.

Source files
------------

// File: rtl/mem_pattern_pkg.sv
// mem_pattern_pkg: shared state encoding and LFSR step function for the memory pattern initiator
package mem_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l, input logic [31:0] poly);
        return (l >> 1) ^ (l[0] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/mem_pattern_lfsr.sv
// mem_pattern_lfsr: Galois LFSR that reloads its seed on demand, with a zero seed forced to 1
module mem_pattern_lfsr
    import mem_pattern_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    // Load wins over step so the write and read passes both start from the same seed
    always_ff @(posedge clk) begin
        if (load)
            value <= (seed == 32'h0) ? 32'h1 : seed;
        else if (step)
            value <= lfsr_next(value, POLY);
    end

endmodule

// File: rtl/mem_pattern_initiator.sv
// mem_pattern_initiator: writes an LFSR pattern over a word range, reads it back and reports mismatches
module mem_pattern_initiator
    import mem_pattern_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          NWORDS    = 256,
    parameter logic [31:0] SEED      = 32'h1,
    parameter logic [31:0] POLY      = DEFAULT_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_exp,
    output logic [31:0] fail_got,
    output logic [31:0] Address,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    output logic        MemRead,
    input  logic [31:0] Read_data
);

    state_t      r_state;
    logic [15:0] r_idx;
    logic        r_pass;
    logic [15:0] r_err;
    logic [31:0] r_fail_addr;
    logic [31:0] r_fail_exp;
    logic [31:0] r_fail_got;
    logic [31:0] w_lfsr;
    logic [31:0] w_addr;
    logic        w_last;
    logic        w_mis;
    logic        w_load;
    logic        w_step;

    mem_pattern_lfsr #(.POLY(POLY)) u_lfsr (
        .clk  (clk),
        .load (w_load),
        .step (w_step),
        .seed (SEED),
        .value(w_lfsr)
    );

    // Strobes are gated by rst so a reset cycle never touches memory, even mid-test
    always_comb begin
        w_last     = r_idx == 16'(NWORDS - 1);
        w_addr     = ADDR_BASE + {14'd0, r_idx, 2'b00};
        w_mis      = (r_state == READ) && (Read_data != w_lfsr);
        w_load     = ((r_state == IDLE) && start) || ((r_state == WRITE) && w_last);
        w_step     = (r_state == WRITE) || (r_state == READ);
        MemWrite   = !rst && (r_state == WRITE);
        MemRead    = !rst && (r_state == READ);
        Write_strb = {4{MemWrite}};
        Address    = (MemWrite || MemRead) ? w_addr : 32'h0;
        Write_data = MemWrite ? w_lfsr : 32'h0;
        busy       = (r_state == WRITE) || (r_state == READ);
        done       = r_state == DONE;
        pass       = r_pass;
        err_count  = r_err;
        fail_addr  = r_fail_addr;
        fail_exp   = r_fail_exp;
        fail_got   = r_fail_got;
    end

    // Sequencer: write pass, read-and-compare pass, one-cycle done, back to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 16'd0;
            r_pass      <= 1'b0;
            r_err       <= 16'd0;
            r_fail_addr <= 32'h0;
            r_fail_exp  <= 32'h0;
            r_fail_got  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state     <= WRITE;
                    r_idx       <= 16'd0;
                    r_pass      <= 1'b0;
                    r_err       <= 16'd0;
                    r_fail_addr <= 32'h0;
                    r_fail_exp  <= 32'h0;
                    r_fail_got  <= 32'h0;
                end
                WRITE: begin
                    r_idx   <= w_last ? 16'd0 : r_idx + 16'd1;
                    r_state <= w_last ? READ : WRITE;
                end
                READ: begin
                    r_idx <= r_idx + 16'd1;
                    if (w_mis && r_err != 16'hFFFF)
                        r_err <= r_err + 16'd1;
                    if (w_mis && r_err == 16'd0) begin
                        r_fail_addr <= w_addr;
                        r_fail_exp  <= w_lfsr;
                        r_fail_got  <= Read_data;
                    end
                    if (w_last) begin
                        r_state <= DONE;
                        r_pass  <= (r_err == 16'd0) && !w_mis;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_pattern_initiator.sv
// tb_mem_pattern_initiator: directed checks of the pattern initiator against an ideal RAM with fault injection
module tb_mem_pattern_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, a_busy, a_done, a_pass, a_mw, a_mr;
    logic [15:0] a_err;
    logic [31:0] a_fa, a_fe, a_fg, a_addr, a_wd, a_rd;
    logic [3:0]  a_ws;
    logic        b_start, b_busy, b_done, b_pass, b_mw, b_mr;
    logic [15:0] b_err;
    logic [31:0] b_fa, b_fe, b_fg, b_addr, b_wd, b_rd;
    logic [3:0]  b_ws;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] f_addr0 = 32'h0, f_mask0 = 32'h0, f_addr1 = 32'h0, f_mask1 = 32'h0;
    logic [31:0] pat [4] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_pattern_initiator #(.ADDR_BASE(32'h0), .NWORDS(4), .SEED(32'h1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .fail_addr(a_fa), .fail_exp(a_fe), .fail_got(a_fg),
        .Address(a_addr), .MemWrite(a_mw), .Write_data(a_wd), .Write_strb(a_ws),
        .MemRead(a_mr), .Read_data(a_rd)
    );

    mem_pattern_initiator #(.ADDR_BASE(32'hFFFFFFFC), .NWORDS(2), .SEED(32'h0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .fail_addr(b_fa), .fail_exp(b_fe), .fail_got(b_fg),
        .Address(b_addr), .MemWrite(b_mw), .Write_data(b_wd), .Write_strb(b_ws),
        .MemRead(b_mr), .Read_data(b_rd)
    );

    always @(posedge clk) begin
        if (a_mw) mem_a[a_addr[11:2]] <= a_wd;
        if (b_mw) mem_b[b_addr[11:2]] <= b_wd;
    end

    assign a_rd = mem_a[a_addr[11:2]] ^ ((a_addr == f_addr0) ? f_mask0 : 32'h0)
                                      ^ ((a_addr == f_addr1) ? f_mask1 : 32'h0);
    assign b_rd = mem_b[b_addr[11:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulses start, then checks every cycle 1..10 of one NWORDS=4 test; ign>0 re-pulses start at that cycle
    task automatic run_test(input string name, input int ign, input logic ep, input logic [15:0] ee,
                            input logic [31:0] efa, input logic [31:0] efe, input logic [31:0] efg);
        a_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            a_start = (k == ign);
            check($sformatf("%s done c%0d", name, k), 32'(a_done), 32'(k == 9));
            check($sformatf("%s busy c%0d", name, k), 32'(a_busy), 32'(k <= 8));
            if (k == 1) begin
                check({name, " pass cleared"}, 32'(a_pass), 32'h0);
                check({name, " err cleared"}, 32'(a_err), 32'h0);
            end
            if (k <= 4) begin
                check($sformatf("%s wr_en c%0d", name, k), 32'(a_mw), 32'h1);
                check($sformatf("%s wr_addr c%0d", name, k), a_addr, 32'(4 * (k - 1)));
                check($sformatf("%s wr_data c%0d", name, k), a_wd, pat[k-1]);
                check($sformatf("%s wr_strb c%0d", name, k), 32'(a_ws), 32'hF);
                check($sformatf("%s rd_en c%0d", name, k), 32'(a_mr), 32'h0);
            end else if (k <= 8) begin
                check($sformatf("%s rd_en c%0d", name, k), 32'(a_mr), 32'h1);
                check($sformatf("%s rd_addr c%0d", name, k), a_addr, 32'(4 * (k - 5)));
                check($sformatf("%s wr_en c%0d", name, k), 32'(a_mw), 32'h0);
                check($sformatf("%s rd_strb c%0d", name, k), 32'(a_ws), 32'h0);
            end else begin
                check($sformatf("%s strobes c%0d", name, k), {30'h0, a_mw, a_mr}, 32'h0);
                check($sformatf("%s pass c%0d", name, k), 32'(a_pass), 32'(ep));
            end
            if (k == 9) begin
                check({name, " err_count"}, 32'(a_err), 32'(ee));
                check({name, " fail_addr"}, a_fa, efa);
                check({name, " fail_exp"}, a_fe, efe);
                check({name, " fail_got"}, a_fg, efg);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        rst = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(a_busy), 32'h0);
        check("rst done", 32'(a_done), 32'h0);
        check("rst pass", 32'(a_pass), 32'h0);
        check("rst err", 32'(a_err), 32'h0);
        check("rst fail_addr", a_fa, 32'h0);
        check("rst fail_exp", a_fe, 32'h0);
        check("rst fail_got", a_fg, 32'h0);
        check("rst Address", a_addr, 32'h0);
        check("rst Write_data", a_wd, 32'h0);
        check("rst Write_strb", 32'(a_ws), 32'h0);
        check("rst strobes", {30'h0, a_mw, a_mr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_test("clean", 0, 1'b1, 16'd0, 32'h0, 32'h0, 32'h0);
        run_test("b2b_busy_start", 3, 1'b1, 16'd0, 32'h0, 32'h0, 32'h0);

        f_addr0 = 32'h4;
        f_mask0 = 32'h8;
        run_test("stuck", 0, 1'b0, 16'd1, 32'h4, 32'h80200003, 32'h8020000B);

        f_addr0 = 32'h8;
        f_mask0 = 32'h1;
        f_addr1 = 32'hC;
        f_mask1 = 32'h80000000;
        run_test("multi", 0, 1'b0, 16'd2, 32'h8, 32'hC0300002, 32'hC0300003);
        f_mask0 = 32'h0;
        f_mask1 = 32'h0;

        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        check("midrst wr_en before", 32'(a_mw), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst wr_en gated", 32'(a_mw), 32'h0);
        check("midrst strb gated", 32'(a_ws), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("midrst busy %0d", k), 32'(a_busy), 32'h0);
            check($sformatf("midrst done %0d", k), 32'(a_done), 32'h0);
            @(negedge clk);
        end
        run_test("after_rst", 0, 1'b1, 16'd0, 32'h0, 32'h0, 32'h0);

        b_start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            check($sformatf("edge done c%0d", k), 32'(b_done), 32'(k == 5));
            if (k == 1) begin
                check("edge wr_addr0", b_addr, 32'hFFFFFFFC);
                check("edge wr_data0", b_wd, 32'h00000001);
                check("edge wr_en0", 32'(b_mw), 32'h1);
            end
            if (k == 2) begin
                check("edge wr_addr1 wrap", b_addr, 32'h00000000);
                check("edge wr_data1", b_wd, 32'h80200003);
            end
            if (k == 3) begin
                check("edge rd_addr0", b_addr, 32'hFFFFFFFC);
                check("edge rd_en0", 32'(b_mr), 32'h1);
            end
            if (k == 4) check("edge rd_addr1", b_addr, 32'h00000000);
            if (k == 5) begin
                check("edge pass", 32'(b_pass), 32'h1);
                check("edge err", 32'(b_err), 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
